// File: rtl/dl_skid_buf_if.sv
// Handshake bundle for the 2-entry skid buffer: upstream in_* side, downstream
// out_* side, plus the synchronous flush and the occupancy count.
interface dl_skid_buf_if #(
  parameter int NUM_BITS = 32
);
  // A beat moves on a channel exactly on a rising edge where valid and ready are
  // both 1; a producer holding valid keeps its data stable until that edge.
  logic                flush;
  logic                in_valid;
  logic [NUM_BITS-1:0] in_data;
  logic                in_ready;
  logic                out_valid;
  logic [NUM_BITS-1:0] out_data;
  logic                out_ready;
  logic [1:0]          count;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/dl_skid_buf.sv
// Two-entry valid/ready skid buffer: MAIN drives out_data, SKID catches the one
// beat accepted while downstream stalls, so in_ready never depends on out_ready.
module dl_skid_buf #(
  parameter int                  NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0] RST_VAL  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  dl_skid_buf_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_n;
  logic [NUM_BITS-1:0] main_q, main_n;
  logic [NUM_BITS-1:0] skid_q, skid_n;
  logic [1:0]          count_q, count_n;
  logic                in_fire;
  logic                out_fire;

  // in_ready comes only from registered state, flush and reset.
  assign bus.in_ready  = (state_q != FULL) & ~bus.flush & rst_n;
  assign bus.out_valid = (state_q == ONE) | (state_q == FULL);
  assign bus.out_data  = main_q;
  assign bus.count     = count_q;
  assign state_dbg     = state_q;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    state_n = state_q;
    main_n  = main_q;
    skid_n  = skid_q;
    count_n = count_q;
    if (bus.flush) begin
      state_n = EMPTY;
      main_n  = RST_VAL;
      skid_n  = RST_VAL;
      count_n = 2'd0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_n = ONE;
            main_n  = bus.in_data;
            count_n = 2'd1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_n = bus.in_data;
          end else if (in_fire) begin
            state_n = FULL;
            skid_n  = bus.in_data;
            count_n = 2'd2;
          end else if (out_fire) begin
            state_n = EMPTY;
            count_n = 2'd0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_n = ONE;
            main_n  = skid_q;
            count_n = 2'd1;
          end
        end
        // The unused encoding falls back to EMPTY and drops whatever it held.
        default: begin
          state_n = EMPTY;
          count_n = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
      count_q <= 2'd0;
    end else begin
      state_q <= state_n;
      main_q  <= main_n;
      skid_q  <= skid_n;
      count_q <= count_n;
    end
  end

endmodule

// File: tb/tb_dl_skid_buf.sv
// Bench for dl_skid_buf: directed scenarios followed by a randomized run
// against a capacity-2 FIFO queue model.
module tb_dl_skid_buf;
  localparam int         W       = 8;
  localparam logic [W-1:0] RST_VAL = 8'hC3;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         errors = 0;
  int         checks = 0;
  logic [W-1:0] exp_q[$];

  dl_skid_buf_if #(.NUM_BITS(W)) bus ();

  dl_skid_buf #(.NUM_BITS(W), .RST_VAL(RST_VAL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.flush     = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #12;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.out_data !== RST_VAL) begin errors++; $display("FAIL reset_out_data: got %h want %h", bus.out_data, RST_VAL); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", bus.out_data); end
    checks++; if (bus.count !== 2'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.count); end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL single_drain_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_stall();
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    checks++; if (bus.count !== 2'd2) begin errors++; $display("FAIL stall_count: got %0d want 2", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL stall_data: got %h want 11", bus.out_data); end
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL stall_state: got %0d want 2", state_dbg); end
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    tick();
    checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL stall_hold: got %h want 11", bus.out_data); end
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    checks++; if (bus.out_data !== 8'h11 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL drain_first: got %h/%b want 11/1", bus.out_data, bus.out_valid); end
    tick();
    checks++; if (bus.out_data !== 8'h22 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL drain_second: got %h/%b want 22/1", bus.out_data, bus.out_valid); end
    checks++; if (bus.count !== 2'd1) begin errors++; $display("FAIL drain_count1: got %0d want 1", bus.count); end
    tick();
    checks++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %0d/%b want 0/0", bus.count, bus.out_valid); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== W'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h/%b want %h/1", i, bus.out_data, bus.out_valid, W'(i)); end
      checks++; if (bus.count !== 2'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", i, bus.count); end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL stream_end_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_flush();
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    tick();
    checks++; if (bus.count !== 2'd2) begin errors++; $display("FAIL flush_pre_count: got %0d want 2", bus.count); end
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    tick();
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== RST_VAL) begin errors++; $display("FAIL flush_data: got %h want %h", bus.out_data, RST_VAL); end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.out_data === 8'h55) begin errors++; $display("FAIL flush_ghost[%0d]: got %h/%b want none", i, bus.out_data, bus.out_valid); end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b want 1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL areset_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.count !== 2'd0 || bus.out_data !== RST_VAL) begin errors++; $display("FAIL areset_state: got %0d/%h want 0/%h", bus.count, bus.out_data, RST_VAL); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h77) begin errors++; $display("FAIL areset_push: got %h/%b want 77/1", bus.out_data, bus.out_valid); end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
  endtask

  // scoreboard run: exp_q is a capacity-2 FIFO with flush clearing it
  task automatic test_random();
    logic       iv, ordy, fl, exp_rdy, in_fire, out_fire, prev_stall;
    logic [W-1:0] id, prev_front;
    int         delivered;
    int         bias;
    prev_stall = 1'b0;
    prev_front = '0;
    delivered  = 0;
    exp_q.delete();
    bias = 2;
    for (int c = 0; c < 10000; c++) begin
      checks++; if (bus.out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, bus.out_valid, exp_q.size() != 0); end
      checks++; if (bus.count !== 2'(exp_q.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, bus.count, exp_q.size()); end
      if (exp_q.size() != 0) begin
        checks++; if (bus.out_data !== exp_q[0]) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", c, bus.out_data, exp_q[0]); end
      end
      if (prev_stall) begin
        checks++; if (bus.out_data !== prev_front) begin errors++; $display("FAIL rnd_stall_stable[%0d]: got %h want %h", c, bus.out_data, prev_front); end
      end
      if (c % 200 == 0) bias = $urandom_range(1, 3);
      iv   = ($urandom_range(0, 3) != 0);
      id   = W'($urandom_range(0, 255));
      ordy = ($urandom_range(0, 3) < bias);
      fl   = ($urandom_range(0, 63) == 0);
      drive(iv, id, ordy, fl);
      #1;
      exp_rdy = (exp_q.size() < 2) && !fl;
      checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, bus.in_ready, exp_rdy); end
      in_fire    = iv && exp_rdy;
      out_fire   = (exp_q.size() != 0) && ordy;
      prev_stall = (exp_q.size() != 0) && !ordy && !fl;
      prev_front = (exp_q.size() != 0) ? exp_q[0] : '0;
      if (fl) begin
        exp_q.delete();
      end else begin
        if (out_fire) begin
          void'(exp_q.pop_front());
          delivered++;
        end
        if (in_fire) exp_q.push_back(id);
      end
      tick();
    end
    checks++; if (delivered < 1000) begin errors++; $display("FAIL rnd_throughput: got %0d want >=1000 beats", delivered); end
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_stream();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dl_skid_buf.md
DL_SKID_BUF -- requirements
Module: dl_skid_buf

Interface
REQ-001 Parameter NUM_BITS, default 32, payload width in bits.
REQ-002 Parameter RST_VAL, default 0, value loaded into both data registers on reset and flush.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_data  input  NUM_BITS  upstream payload.
REQ-008 in_ready  output  1  buffer accepts in_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_data  output  NUM_BITS  oldest held payload; drives the d input of a downstream enable register.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle; usable directly as that register's en.
REQ-012 count  output  2  entries held, 0..2.

Function
REQ-013 The block SHALL be a 2-entry valid/ready skid buffer: a main register (MAIN) drives out_data and a skid register (SKID) absorbs one beat when downstream stalls.
REQ-014 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-015 The state machine SHALL have three states: EMPTY (count 0), ONE (count 1, MAIN valid), FULL (count 2, MAIN and SKID valid).
REQ-016 out_valid SHALL be 1 in ONE and FULL, else 0; out_data SHALL equal MAIN in all states.
REQ-017 in_ready SHALL be (state != FULL) & ~flush & rst_n; it SHALL have no combinational path from out_ready or in_valid.
REQ-018 EMPTY: in_fire -> ONE, MAIN <= in_data; otherwise stay in EMPTY.
REQ-019 ONE: in_fire & out_fire -> ONE, MAIN <= in_data; in_fire & ~out_fire -> FULL, SKID <= in_data; ~in_fire & out_fire -> EMPTY; neither -> hold.
REQ-020 FULL: out_fire -> ONE, MAIN <= SKID; otherwise hold. in_ready is 0, so no input is taken.
REQ-021 Latency SHALL be 1 cycle: a beat accepted at edge N is presented on out_data/out_valid after edge N.
REQ-022 Ordering SHALL be strict FIFO; no beat is dropped or duplicated except by flush or reset.
REQ-023 Throughput SHALL be 1 beat/cycle while out_ready stays 1.
REQ-024 flush SHALL take priority over all handshakes: at the next edge state -> EMPTY, MAIN and SKID <= RST_VAL, count <= 0. in_ready is 0 during flush, so no beat is accepted. A beat presented with out_valid & out_ready during flush counts as consumed.
REQ-025 While out_valid = 1 and out_ready = 0, out_data SHALL stay stable.
REQ-026 count SHALL be registered and SHALL never exceed 2; count 3 is unreachable.
REQ-027 The encoding of the unused 4th state (if any) SHALL recover to EMPTY on the next edge.

Reset
REQ-028 While rst_n = 0, asynchronously: state = EMPTY, MAIN = SKID = RST_VAL, out_valid = 0, count = 0, in_ready = 0.
REQ-029 On the first edge after rst_n deasserts, in_ready SHALL be 1 if flush = 0.
REQ-030 A reset asserted mid-transfer SHALL discard all held entries with no partial update.

Verification
REQ-031 Reset, then in_valid = 1 with in_data = 0xA5, out_ready = 1, for one cycle -> next cycle out_valid = 1, out_data = 0xA5, count = 1; the cycle after that out_valid = 0.
REQ-032 out_ready = 0; push 0x11 then 0x22 -> count = 2, in_ready = 0, out_data = 0x11. Raise out_ready -> 0x11 then 0x22 delivered on consecutive cycles, then count = 0.
REQ-033 out_ready = 1; stream 0x01..0x10 for 16 consecutive cycles -> 16 beats out in order, in_ready stays 1, count stays 1.
REQ-034 FULL with 0x33/0x44; assert flush for 1 cycle with in_valid = 1 and in_data = 0x55 -> in_ready = 0 that cycle, then count = 0, out_valid = 0, out_data = RST_VAL, and 0x55 never appears.
REQ-035 In ONE, drop rst_n asynchronously between edges -> out_valid = 0, in_ready = 0 immediately. After release, push 0x77 -> it appears with latency 1.
REQ-036 Random valid/ready for 10k cycles against a scoreboard queue -> no loss, no reorder, and out_data stable whenever stalled.
